// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the fetch/decode pipeline register.
package if_id_stage_pkg;

  localparam int unsigned INSTR_W          = 16;
  localparam int unsigned PC_W             = 32;
  localparam int unsigned IMM_FLAG_BIT_DEF = 15;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 16'h0000;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_IMM   = 1'b1
  } state_t;

endpackage

// File: rtl/if_id_stage_imm_assembler.sv
// Joins an opcode word carrying the immediate flag with the following word
// so that decode receives a two-word instruction as one slot.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   S_FIRST | expecting an opcode word (or plain one-word instr)
//   S_IMM   | opcode word held, next word is its immediate
module if_id_stage_imm_assembler
  import if_id_stage_pkg::*;
#(
  parameter int unsigned IMM_FLAG_BIT = IMM_FLAG_BIT_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_advance,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_word,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_imm,
  output logic               o_has_imm,
  output logic               o_ready,
  output logic               o_in_first
);

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] held_word;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_FIRST;
    else          state <= state_nxt;
  end

  // Next-state: clear wins, otherwise only move when the top lets us advance
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = S_FIRST;
    end else if (i_advance) begin
      case (state)
        S_FIRST: if (i_word[IMM_FLAG_BIT]) state_nxt = S_IMM;
        S_IMM:   state_nxt = S_FIRST;
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  // Held opcode word; dropped on clear so a flushed opcode cannot resurface
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      held_word <= '0;
    end else if (i_clear) begin
      held_word <= '0;
    end else if (i_advance && (state == S_FIRST) && i_word[IMM_FLAG_BIT]) begin
      held_word <= i_word;
    end
  end

  // Outputs: what a capture this cycle would present to decode
  always_comb begin
    o_in_first = (state == S_FIRST);
    o_has_imm  = (state == S_IMM);
    o_instr    = (state == S_IMM) ? held_word : i_word;
    o_imm      = i_word;
    o_ready    = (state == S_IMM) || !i_word[IMM_FLAG_BIT];
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with two-word assembly, stall, flush
// and interrupt injection. Decode sees one full instruction or a bubble.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned        IMM_FLAG_BIT = IMM_FLAG_BIT_DEF,
  parameter logic [INSTR_W-1:0] NOP_WORD     = NOP_WORD_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc_inc,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_interrupt,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_imm,
  output logic [PC_W-1:0]    o_pc_inc,
  output logic               o_valid,
  output logic               o_has_imm,
  output logic               o_int
);

  logic               int_pending;
  logic               inject;
  logic               advance;
  logic               asm_ready;
  logic               asm_has_imm;
  logic               asm_in_first;
  logic [INSTR_W-1:0] asm_instr;
  logic [INSTR_W-1:0] asm_imm;

  // Interrupts only enter between instructions, never between opcode and immediate
  assign inject  = int_pending && asm_in_first;
  assign advance = !i_flush && !i_stall && !inject;

  if_id_stage_imm_assembler #(
    .IMM_FLAG_BIT (IMM_FLAG_BIT)
  ) u_imm_asm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_advance  (advance),
    .i_clear    (i_flush),
    .i_word     (i_instr),
    .o_instr    (asm_instr),
    .o_imm      (asm_imm),
    .o_has_imm  (asm_has_imm),
    .o_ready    (asm_ready),
    .o_in_first (asm_in_first)
  );

  // Pending interrupt: a new request always sets it, issuing a slot clears it
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      int_pending <= 1'b0;
    end else begin
      int_pending <= i_interrupt || (int_pending && !(inject && !i_flush && !i_stall));
    end
  end

  // Decode slot: flush > stall > interrupt slot > normal capture
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_instr   <= NOP_WORD;
      o_imm     <= '0;
      o_pc_inc  <= '0;
      o_valid   <= 1'b0;
      o_has_imm <= 1'b0;
      o_int     <= 1'b0;
    end else if (i_flush) begin
      o_instr   <= NOP_WORD;
      o_valid   <= 1'b0;
      o_has_imm <= 1'b0;
      o_int     <= 1'b0;
    end else if (i_stall) begin
      o_instr   <= o_instr;
    end else if (inject) begin
      // Point back at the word being dropped so it re-executes after the handler
      o_instr   <= NOP_WORD;
      o_pc_inc  <= i_pc_inc - 32'd1;
      o_valid   <= 1'b1;
      o_has_imm <= 1'b0;
      o_int     <= 1'b1;
    end else if (asm_ready) begin
      o_instr   <= asm_instr;
      o_pc_inc  <= i_pc_inc;
      o_valid   <= 1'b1;
      o_has_imm <= asm_has_imm;
      o_int     <= 1'b0;
      if (asm_has_imm) o_imm <= asm_imm;
    end else begin
      // Opcode half of a two-word instruction: nothing complete yet
      o_instr   <= NOP_WORD;
      o_valid   <= 1'b0;
      o_has_imm <= 1'b0;
      o_int     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_instr;
  logic [31:0] i_pc_inc;
  logic        i_stall;
  logic        i_flush;
  logic        i_interrupt;
  logic [15:0] o_instr;
  logic [15:0] o_imm;
  logic [31:0] o_pc_inc;
  logic        o_valid;
  logic        o_has_imm;
  logic        o_int;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  if_id_stage dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_instr     (i_instr),
    .i_pc_inc    (i_pc_inc),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_interrupt (i_interrupt),
    .o_instr     (o_instr),
    .o_imm       (o_imm),
    .o_pc_inc    (o_pc_inc),
    .o_valid     (o_valid),
    .o_has_imm   (o_has_imm),
    .o_int       (o_int)
  );

  typedef struct {
    logic [15:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        intr;
    logic        e_valid;
    logic        e_int;
    logic        e_has_imm;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic v, input logic it, input logic hi,
                           input logic [15:0] ins, input logic [15:0] imm, input logic [31:0] pc);
    check("o_valid",   idx, {31'd0, o_valid},   {31'd0, v});
    check("o_int",     idx, {31'd0, o_int},     {31'd0, it});
    check("o_has_imm", idx, {31'd0, o_has_imm}, {31'd0, hi});
    check("o_instr",   idx, {16'd0, o_instr},   {16'd0, ins});
    check("o_imm",     idx, {16'd0, o_imm},     {16'd0, imm});
    check("o_pc_inc",  idx, o_pc_inc, pc);
  endtask

  task automatic drive(input logic [15:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl, input logic it);
    i_instr     = ins;
    i_pc_inc    = pc;
    i_stall     = st;
    i_flush     = fl;
    i_interrupt = it;
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic [15:0] ins, input logic [31:0] pc, input logic st,
                     input logic fl, input logic it, input logic v, input logic iv,
                     input logic hi, input logic [15:0] ei, input logic [15:0] em,
                     input logic [31:0] ep);
    vec_t r;
    r.instr = ins; r.pc = pc; r.stall = st; r.flush = fl; r.intr = it;
    r.e_valid = v; r.e_int = iv; r.e_has_imm = hi;
    r.e_instr = ei; r.e_imm = em; r.e_pc = ep;
    vecs.push_back(r);
  endtask

  initial begin
    //    instr     pc      st fl it  v  int hi  e_instr   e_imm     e_pc
    add(16'h1234, 32'd5,  0, 0, 0,  1, 0, 0, 16'h1234, 16'h0000, 32'd5);
    add(16'h8001, 32'd10, 0, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 32'd5);
    add(16'hBEEF, 32'd11, 0, 0, 0,  1, 0, 1, 16'h8001, 16'hBEEF, 32'd11);
    add(16'h1234, 32'd12, 0, 0, 0,  1, 0, 0, 16'h1234, 16'hBEEF, 32'd12);
    add(16'h5555, 32'd99, 1, 0, 0,  1, 0, 0, 16'h1234, 16'hBEEF, 32'd12);
    add(16'h8AAA, 32'd77, 1, 0, 0,  1, 0, 0, 16'h1234, 16'hBEEF, 32'd12);
    add(16'h0F0F, 32'd3,  1, 0, 0,  1, 0, 0, 16'h1234, 16'hBEEF, 32'd12);
    add(16'h8003, 32'd13, 1, 1, 0,  0, 0, 0, 16'h0000, 16'hBEEF, 32'd12);
    add(16'h8001, 32'd20, 0, 0, 0,  0, 0, 0, 16'h0000, 16'hBEEF, 32'd12);
    add(16'hBEEF, 32'd21, 0, 1, 0,  0, 0, 0, 16'h0000, 16'hBEEF, 32'd12);
    add(16'h0042, 32'd22, 0, 0, 0,  1, 0, 0, 16'h0042, 16'hBEEF, 32'd22);
    add(16'h8005, 32'd30, 0, 0, 0,  0, 0, 0, 16'h0000, 16'hBEEF, 32'd22);
    add(16'h1111, 32'd31, 0, 0, 1,  1, 0, 1, 16'h8005, 16'h1111, 32'd31);
    add(16'h2222, 32'd20, 0, 0, 0,  1, 1, 0, 16'h0000, 16'h1111, 32'd19);
    add(16'h2222, 32'd20, 0, 0, 0,  1, 0, 0, 16'h2222, 16'h1111, 32'd20);
    add(16'h3333, 32'd40, 0, 1, 1,  0, 0, 0, 16'h0000, 16'h1111, 32'd20);
    add(16'h4444, 32'd0,  0, 0, 0,  1, 1, 0, 16'h0000, 16'h1111, 32'hFFFFFFFF);
    add(16'h4444, 32'd0,  0, 0, 0,  1, 0, 0, 16'h4444, 16'h1111, 32'd0);
    add(16'h6666, 32'd50, 1, 0, 1,  1, 0, 0, 16'h4444, 16'h1111, 32'd0);
    add(16'h6666, 32'd50, 0, 0, 0,  1, 1, 0, 16'h0000, 16'h1111, 32'd49);

    i_reset = 1'b0;
    i_instr = 16'h0; i_pc_inc = 32'd0;
    i_stall = 1'b0; i_flush = 1'b0; i_interrupt = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all(-1, 0, 0, 0, 16'h0000, 16'h0000, 32'd0);
    i_reset = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].stall, vecs[k].flush, vecs[k].intr);
      check_all(k, vecs[k].e_valid, vecs[k].e_int, vecs[k].e_has_imm,
                vecs[k].e_instr, vecs[k].e_imm, vecs[k].e_pc);
    end

    // Reset while holding an opcode word: everything clears at once, held word lost
    drive(16'h0077, 32'd60, 0, 0, 0);
    drive(16'h8009, 32'd61, 0, 0, 0);
    check_all(100, 0, 0, 0, 16'h0000, 16'h1111, 32'd60);
    i_instr = 16'hCAFE;
    #2;
    i_reset = 1'b0;
    #1;
    check_all(101, 0, 0, 0, 16'h0000, 16'h0000, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    drive(16'h1234, 32'd5, 0, 0, 0);
    check_all(102, 1, 0, 0, 16'h1234, 16'h0000, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
